// File: rtl/midi_pkg.sv
// Shared constants and FSM state encoding for the MIDI channel-message parser.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRES   = 4'hD;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  localparam logic [7:0] ACTIVE_SENSE = 8'hFE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_D1   = 2'd1,
    S_D2   = 2'd2
  } state_t;

endpackage

// File: rtl/midi_msg_parser_active_sense.sv
// Active-sensing watchdog: armed by 0xFE, reloaded by any byte, fires once on expiry.
module midi_active_sense
  import midi_pkg::*;
#(
  parameter int unsigned P_TIMEOUT = 15_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       expire
);

  localparam int unsigned W = $clog2(P_TIMEOUT + 1);
  localparam logic [W-1:0] LOAD = W'(P_TIMEOUT - 1);

  logic [W-1:0] count;
  logic         armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      count <= '0;
    end else if (rx_valid) begin
      count <= LOAD;
      if (rx_data == ACTIVE_SENSE) armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) armed <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign expire = armed && !rx_valid && (count == '0);

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI 1.0 channel-message parser producing NoteOn/NoteOff/AllOff pulses.
// Optional active-sensing timeout enabled by defining MIDI_ACTIVE_SENSE_EN.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int unsigned P_OMNI          = 1,
  parameter int unsigned P_SENSE_TIMEOUT = 15_000_000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iRxData,
  input  logic       iRxValid,
  input  logic [3:0] iChannelSel,
  output logic [6:0] oNoteNumber,
  output logic [6:0] oVelocity,
  output logic       oNoteOn,
  output logic       oNoteOff,
  output logic       oAllOff
);

  state_t     state, state_n;
  logic [7:0] status, status_n;
  logic [6:0] data1, data1_n;
  logic [6:0] note_n, vel_n;
  logic       on_n, off_n, all_n;
  logic       done;
  logic       chan_ok;

`ifdef MIDI_ACTIVE_SENSE_EN
  logic sense_fire;
  logic pending, pending_n;

  midi_active_sense #(
    .P_TIMEOUT(P_SENSE_TIMEOUT)
  ) u_sense (
    .clk     (iCLK),
    .rst     (iRST),
    .rx_data (iRxData),
    .rx_valid(iRxValid),
    .expire  (sense_fire)
  );
`else
  logic unused_sense_timeout;
  assign unused_sense_timeout = (P_SENSE_TIMEOUT != 0);
`endif

  assign chan_ok = (P_OMNI != 0) || (status[3:0] == iChannelSel);

  always_comb begin
    state_n  = state;
    status_n = status;
    data1_n  = data1;
    note_n   = oNoteNumber;
    vel_n    = oVelocity;
    on_n     = 1'b0;
    off_n    = 1'b0;
    all_n    = 1'b0;
    done     = 1'b0;
`ifdef MIDI_ACTIVE_SENSE_EN
    pending_n = pending;
`endif
    // Real-time bytes (F8-FF) fall through every branch and leave state untouched.
    if (iRxValid && (iRxData[7:3] != 5'b11111)) begin
      if (iRxData[7:4] == 4'hF) begin
        status_n = '0;
        state_n  = S_IDLE;
      end else if (iRxData[7]) begin
        status_n = iRxData;
        state_n  = S_D1;
      end else begin
        case (state)
          S_D1: begin
            data1_n = iRxData[6:0];
            if (status[7:4] == PROG || status[7:4] == CHPRES) done = 1'b1;
            else                                              state_n = S_D2;
          end
          S_D2: begin
            done    = 1'b1;
            state_n = S_D1;
          end
          default: ;
        endcase
      end
    end

    if (done && chan_ok) begin
      case (status[7:4])
        NOTE_ON: begin
          note_n = data1;
          vel_n  = iRxData[6:0];
          if (iRxData[6:0] != '0) on_n  = 1'b1;
          else                    off_n = 1'b1;
        end
        NOTE_OFF: begin
          note_n = data1;
          vel_n  = iRxData[6:0];
          off_n  = 1'b1;
        end
        CC: begin
          if (data1 == CC_ALL_SOUND_OFF || data1 == CC_ALL_NOTES_OFF) all_n = 1'b1;
        end
        default: ;
      endcase
    end

`ifdef MIDI_ACTIVE_SENSE_EN
    // A timeout that collides with a parser event is held one cycle so pulses never overlap.
    if (sense_fire || pending) begin
      if (on_n || off_n || all_n) begin
        pending_n = 1'b1;
      end else begin
        all_n     = 1'b1;
        pending_n = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= S_IDLE;
      status      <= '0;
      data1       <= '0;
      oNoteNumber <= '0;
      oVelocity   <= '0;
      oNoteOn     <= 1'b0;
      oNoteOff    <= 1'b0;
      oAllOff     <= 1'b0;
`ifdef MIDI_ACTIVE_SENSE_EN
      pending     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      status      <= status_n;
      data1       <= data1_n;
      oNoteNumber <= note_n;
      oVelocity   <= vel_n;
      oNoteOn     <= on_n;
      oNoteOff    <= off_n;
      oAllOff     <= all_n;
`ifdef MIDI_ACTIVE_SENSE_EN
      pending     <= pending_n;
`endif
    end
  end

endmodule
